dmem_responder: RTL and testbench

//  Responder end of the CPU data-memory interface: accepts load/store requests over a valid/ready

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_byte_array.sv | 32 +++
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and size encodings for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [3:0] SIZE_1B = 4'b0001;
    localparam logic [3:0] SIZE_2B = 4'b0010;
    localparam logic [3:0] SIZE_4B = 4'b0100;
    localparam logic [3:0] SIZE_8B = 4'b1000;

    typedef struct packed {
        logic [63:0] addr;
        logic        write;
        logic [3:0]  size;
        logic [63:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_byte_array.sv
// rtl/dmem_byte_array.sv - byte storage with 8-lane byte-enable write and 64-bit aligned read
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_BYTES)-4:0] word_addr,
    input  logic [7:0]                     lane_we,
    input  logic [63:0]                    wdata,
    output logic [63:0]                    rdata
);

    // Contents survive reset on purpose, so the storage has no reset term.
    logic [7:0] mem_q [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (lane_we[i]) begin
                mem_q[{word_addr, 3'(i)}] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem_q[{word_addr, 3'(i)}];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder for the CPU data-memory port
// Optional performance counters built when DMEM_RESPONDER_PERF_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_write,
    input  logic [3:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t       req_q, req_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic        size_ok, misaligned, out_of_range, req_err;
    logic [64:0] end_addr;
    logic [7:0]  lane_mask, lane_we;
    logic [63:0] byte_mask, lane_wdata, rd_word, load_data;
    logic [5:0]  lane_shift;
    logic        commit;

    // The one-hot size code doubles as the byte count.
    assign size_ok      = (req_q.size == SIZE_1B) || (req_q.size == SIZE_2B) ||
                          (req_q.size == SIZE_4B) || (req_q.size == SIZE_8B);
    assign misaligned   = (req_q.addr[3:0] & (req_q.size - 4'd1)) != 4'd0;
    assign end_addr     = {1'b0, req_q.addr} + {61'd0, req_q.size};
    assign out_of_range = end_addr > 65'(DEPTH_BYTES);
    assign req_err      = !size_ok || misaligned || out_of_range;

    always_comb begin
        lane_mask = 8'h00;
        case (req_q.size)
            SIZE_1B: lane_mask = 8'h01;
            SIZE_2B: lane_mask = 8'h03;
            SIZE_4B: lane_mask = 8'h0F;
            SIZE_8B: lane_mask = 8'hFF;
            default: lane_mask = 8'h00;
        endcase
        byte_mask = '0;
        for (int i = 0; i < 8; i++) begin
            byte_mask[8*i +: 8] = {8{lane_mask[i]}};
        end
    end

    assign lane_shift = {req_q.addr[2:0], 3'b000};
    assign commit     = (state_q == BUSY) && (cnt_q == '0);
    assign lane_we    = (commit && req_q.write && !req_err) ? (lane_mask << req_q.addr[2:0]) : 8'h00;
    assign lane_wdata = req_q.wdata << lane_shift;
    assign load_data  = (rd_word >> lane_shift) & byte_mask;

    dmem_byte_array #(
        .DEPTH_BYTES(DEPTH_BYTES)
    ) u_array (
        .clk       (clk),
        .word_addr (req_q.addr[AW-1:3]),
        .lane_we   (lane_we),
        .wdata     (lane_wdata),
        .rdata     (rd_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d   = '{addr: req_addr, write: req_write, size: req_size, wdata: req_wdata};
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    err_d   = req_err;
                    rdata_d = (req_err || req_q.write) ? 64'd0 : load_data;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

`ifdef DMEM_RESPONDER_PERF_EN
    logic [31:0] perf_loads_q, perf_loads_d;
    logic [31:0] perf_stores_q, perf_stores_d;

    always_comb begin
        perf_loads_d  = perf_loads_q;
        perf_stores_d = perf_stores_q;
        if (resp_valid && resp_ready && !err_q) begin
            if (req_q.write) begin
                perf_stores_d = perf_stores_q + 32'd1;
            end else begin
                perf_loads_d = perf_loads_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
        end else begin
            perf_loads_q  <= perf_loads_d;
            perf_stores_q <= perf_stores_d;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
`else
    assign perf_loads  = 32'd0;
    assign perf_stores = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [3:0]  req_size = SIZE_8B;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;

    int total = 0;
    int bad   = 0;

    logic [7:0] mm [DEPTH];
    int exp_loads  = 0;
    int exp_stores = 0;

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .perf_loads  (perf_loads),
        .perf_stores (perf_stores)
    );

    always #5 clk = ~clk;

    function automatic bit m_err(input logic [63:0] a, input logic [3:0] s);
        int n;
        if (!(s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8)) return 1'b1;
        n = int'(s);
        if ((a % 64'(n)) != 64'd0) return 1'b1;
        if (a > 64'(DEPTH - n)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] a, input logic [3:0] s);
        logic [63:0] r = '0;
        for (int k = 0; k < int'(s); k++) r[8*k +: 8] = mm[int'(a) + k];
        return r;
    endfunction

    function automatic void m_store(input logic [63:0] a, input logic [3:0] s, input logic [63:0] wd);
        for (int k = 0; k < int'(s); k++) mm[int'(a) + k] = wd[8*k +: 8];
    endfunction

    function automatic logic [63:0] m_expect(input logic [63:0] a, input logic w, input logic [3:0] s);
        if (m_err(a, s) || w) return 64'd0;
        return m_load(a, s);
    endfunction

    // Drives one full transaction from IDLE and records what came back; updates the model.
    task automatic txn(input logic [63:0] a, input logic w, input logic [3:0] s, input logic [63:0] wd,
                       input int hold, output logic [63:0] rd, output logic e, output int lat, output bit to);
        int g = 0;
        to = 1'b0; lat = 0; rd = '0; e = 1'b0;
        req_valid = 1'b1; req_addr = a; req_write = w; req_size = s; req_wdata = wd;
        while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
        if (!req_ready) begin to = 1'b1; req_valid = 1'b0; return; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!resp_valid) begin to = 1'b1; return; end
        rd = resp_rdata; e = resp_err;
        repeat (hold) begin @(posedge clk); #1; end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        if (!m_err(a, s)) begin
            if (w) begin m_store(a, s, wd); exp_stores++; end
            else exp_loads++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        exp_loads = 0; exp_stores = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bit rose = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        total++; if (resp_rdata !== 64'd0) begin bad++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", resp_err); end
        total++; if (perf_loads !== 32'd0 || perf_stores !== 32'd0) begin bad++; $display("FAIL rst_perf: got %0d/%0d want 0/0", perf_loads, perf_stores); end
        reset = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 64'h40; req_write = 1'b1; req_size = SIZE_8B; req_wdata = 64'hDEAD_BEEF_0000_1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL abort_accept: req_ready got %b want 0", req_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_async: req_ready got %b want 1", req_ready); end
        @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (resp_valid) rose = 1'b1; end
        total++; if (rose !== 1'b0) begin bad++; $display("FAIL abort_no_resp: resp_valid rose got %b want 0", rose); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_idle: req_ready got %b want 1", req_ready); end
        total++; if (perf_loads !== 32'd0 || perf_stores !== 32'd0) begin bad++; $display("FAIL abort_perf: got %0d/%0d want 0/0", perf_loads, perf_stores); end
        exp_loads = 0; exp_stores = 0;
    endtask

    task automatic test_fill();
        logic [63:0] rd; logic e; int lat; bit to;
        for (int i = 0; i < 32; i++) begin
            txn(64'(i * 8), 1'b1, SIZE_8B, {$urandom, $urandom}, 0, rd, e, lat, to);
            total++; if (to || e !== 1'b0) begin bad++; $display("FAIL fill_%0d: to=%b err got %b want 0", i, to, e); end
        end
    endtask

    task automatic test_directed();
        logic [63:0] rd, ex; logic e; int lat; bit to;
        txn(64'h10, 1'b1, SIZE_8B, 64'h0123_4567_89AB_CDEF, 0, rd, e, lat, to);
        total++; if (to || e !== 1'b0 || rd !== 64'd0) begin bad++; $display("FAIL st8: to=%b err=%b rdata got %h want 0", to, e, rd); end
        txn(64'h10, 1'b0, SIZE_8B, 64'd0, 0, rd, e, lat, to);
        total++; if (to || rd !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL ld8: got %h want 0123456789abcdef", rd); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL ld8_latency: got %0d want %0d", lat, LAT); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL ld8_err: got %b want 0", e); end
        txn(64'h13, 1'b1, SIZE_1B, 64'h55AA_55AA_55AA_55FF, 0, rd, e, lat, to);
        ex = m_expect(64'h10, 1'b0, SIZE_4B);
        txn(64'h10, 1'b0, SIZE_4B, 64'd0, 0, rd, e, lat, to);
        total++; if (to || rd !== ex || e !== 1'b0) begin bad++; $display("FAIL ld4_sub: got %h err=%b want %h", rd, e, ex); end
        txn(64'h16, 1'b0, SIZE_2B, 64'd0, 1, rd, e, lat, to);
        total++; if (to || rd !== 64'h0123 || e !== 1'b0) begin bad++; $display("FAIL ld2_sub: got %h err=%b want 0123", rd, e); end
    endtask

    task automatic test_errors();
        logic [63:0] rd, ex; logic e; int lat; bit to;
        txn(64'h12, 1'b0, SIZE_4B, 64'd0, 0, rd, e, lat, to);
        total++; if (to || e !== 1'b1 || rd !== 64'd0) begin bad++; $display("FAIL err_misalign: err=%b rdata=%h want 1/0", e, rd); end
        txn(64'(DEPTH - 8), 1'b1, SIZE_8B, 64'h1122_3344_5566_7788, 0, rd, e, lat, to);
        txn(64'(DEPTH), 1'b1, SIZE_8B, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, e, lat, to);
        total++; if (to || e !== 1'b1) begin bad++; $display("FAIL err_oor: err got %b want 1", e); end
        txn(64'hFFFF_FFFF_FFFF_FFF8, 1'b1, SIZE_8B, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, e, lat, to);
        total++; if (to || e !== 1'b1) begin bad++; $display("FAIL err_wrap: err got %b want 1", e); end
        txn(64'h11, 1'b1, SIZE_2B, 64'hFFFF, 0, rd, e, lat, to);
        ex = m_expect(64'(DEPTH - 8), 1'b0, SIZE_8B);
        txn(64'(DEPTH - 8), 1'b0, SIZE_8B, 64'd0, 0, rd, e, lat, to);
        total++; if (to || rd !== ex) begin bad++; $display("FAIL err_nowrite_top: got %h want %h", rd, ex); end
        ex = m_expect(64'h10, 1'b0, SIZE_8B);
        txn(64'h10, 1'b0, SIZE_8B, 64'd0, 0, rd, e, lat, to);
        total++; if (to || rd !== ex) begin bad++; $display("FAIL err_nowrite_mis: got %h want %h", rd, ex); end
        txn(64'h10, 1'b0, 4'b0011, 64'd0, 0, rd, e, lat, to);
        total++; if (to || e !== 1'b1 || rd !== 64'd0) begin bad++; $display("FAIL err_size: err=%b rdata=%h want 1/0", e, rd); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ex1, ex2; int lat = 0;
        ex1 = m_expect(64'h10, 1'b0, SIZE_8B);
        ex2 = m_expect(64'h18, 1'b0, SIZE_8B);
        req_valid = 1'b1; req_addr = 64'h10; req_write = 1'b0; req_size = SIZE_8B;
        @(posedge clk); #1;
        req_addr = 64'h18;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_resp: resp_valid got %b want 1", resp_valid); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== ex1 || req_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold_%0d: valid=%b rdata=%h ready=%b want 1/%h/0", i, resp_valid, resp_rdata, req_ready, ex1);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        exp_loads++;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_idle: req_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_accept2: req_ready got %b want 0", req_ready); end
        lat = 0;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== LAT || resp_rdata !== ex2) begin bad++; $display("FAIL bp_second: lat=%0d rdata=%h want %0d/%h", lat, resp_rdata, LAT, ex2); end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        exp_loads++;
    endtask

    task automatic test_random();
        logic [63:0] a, rd, ex, wd; logic [3:0] s; logic w, e, ee; int lat, sel, n; bit to;
        for (int t = 0; t < 300; t++) begin
            sel = $urandom_range(0, 9);
            n = 1 << $urandom_range(0, 3);
            s = 4'(n);
            if (sel == 0) begin
                do s = 4'($urandom_range(0, 15)); while (s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8);
            end
            a = 64'($urandom_range(0, 255));
            if (sel <= 6) a = a & ~64'(n - 1);
            if (sel == 1) begin
                case ($urandom_range(0, 3))
                    0: a = 64'(DEPTH);
                    1: a = 64'(DEPTH + 8);
                    2: a = 64'hFFFF_FFFF_FFFF_FFF8;
                    default: a = 64'h8000_0000_0000_0000;
                endcase
            end
            w = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            ex = m_expect(a, w, s);
            ee = m_err(a, s);
            txn(a, w, s, wd, $urandom_range(0, 2), rd, e, lat, to);
            total++; if (to || lat !== LAT) begin bad++; $display("FAIL rnd_lat_%0d: to=%b lat got %0d want %0d", t, to, lat, LAT); end
            total++; if (e !== ee) begin bad++; $display("FAIL rnd_err_%0d: a=%h s=%b got %b want %b", t, a, s, e, ee); end
            total++; if (rd !== ex) begin bad++; $display("FAIL rnd_rdata_%0d: a=%h s=%b w=%b got %h want %h", t, a, s, w, rd, ex); end
        end
    endtask

    task automatic check_perf(input string tag);
        int el, es;
`ifdef DMEM_RESPONDER_PERF_EN
        el = exp_loads; es = exp_stores;
`else
        el = 0; es = 0;
`endif
        total++; if (perf_loads !== 32'(el)) begin bad++; $display("FAIL %s_loads: got %0d want %0d", tag, perf_loads, el); end
        total++; if (perf_stores !== 32'(es)) begin bad++; $display("FAIL %s_stores: got %0d want %0d", tag, perf_stores, es); end
    endtask

    task automatic test_perf();
        logic [63:0] rd; logic e; int lat; bit to;
        do_reset();
        for (int i = 0; i < 3; i++) txn(64'(i * 8), 1'b0, SIZE_8B, 64'd0, 0, rd, e, lat, to);
        for (int i = 0; i < 2; i++) txn(64'(64 + i * 4), 1'b1, SIZE_4B, {$urandom, $urandom}, 0, rd, e, lat, to);
        txn(64'h12, 1'b0, SIZE_4B, 64'd0, 0, rd, e, lat, to);
        total++; if (exp_loads !== 3 || exp_stores !== 2) begin bad++; $display("FAIL perf_model: got %0d/%0d want 3/2", exp_loads, exp_stores); end
        check_perf("perf_seq");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_directed();
        test_errors();
        test_back_to_back();
        test_random();
        check_perf("perf_rnd");
        test_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
